// File: rtl/mem_copy_dma.sv
// rtl/mem_copy_dma.sv - word-by-word memory copy engine with range and overlap checking
module mem_copy_dma #(
    parameter int MEM_DEPTH = 200,
    parameter int READ_LAT  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] src_addr,
    input  logic [31:0] dst_addr,
    input  logic [7:0]  length,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [7:0]  words_copied,
    output logic [31:0] adress,
    output logic [31:0] data,
    output logic        memRead,
    output logic        memWrite,
    input  logic [31:0] memOut
);

    localparam int LAT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        READ,
        WAIT,
        WRITE,
        DONE,
        ERROR
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] src_q, dst_q, buf_q, adr_q, data_q;
    logic [7:0]  rem_q, wc_q;
    logic [LAT_W-1:0] wait_cnt;
    logic        last_wait;
    logic [32:0] src_end, dst_end, depth33;
    logic        range_err;

    // 33-bit sums so an address near 2^32 cannot wrap past the depth check
    always_comb begin
        depth33   = 33'(MEM_DEPTH);
        src_end   = {1'b0, src_q} + {25'b0, rem_q};
        dst_end   = {1'b0, dst_q} + {25'b0, rem_q};
        range_err = (src_end > depth33) || (dst_end > depth33) ||
                    ((src_q < dst_q) && ({1'b0, dst_q} < src_end));
        last_wait = (wait_cnt == LAT_W'(READ_LAT - 1));
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = CHECK;
            CHECK: begin
                if (range_err)        state_d = ERROR;
                else if (rem_q == 8'd0) state_d = DONE;
                else                  state_d = READ;
            end
            READ:    state_d = WAIT;
            WAIT:    if (last_wait) state_d = WRITE;
            WRITE:   state_d = (rem_q == 8'd1) ? DONE : READ;
            DONE:    state_d = IDLE;
            ERROR:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Strobes decode straight from state so an async reset drops them at once
    always_comb begin
        busy         = (state_q == CHECK) || (state_q == READ) ||
                       (state_q == WAIT)  || (state_q == WRITE);
        done         = (state_q == DONE);
        error        = (state_q == ERROR);
        memRead      = (state_q == READ) || (state_q == WAIT);
        memWrite     = (state_q == WRITE);
        words_copied = wc_q;
        adress       = memRead ? src_q : (memWrite ? dst_q : adr_q);
        data         = memWrite ? buf_q : data_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            src_q    <= '0;
            dst_q    <= '0;
            rem_q    <= '0;
            wc_q     <= '0;
            buf_q    <= '0;
            adr_q    <= '0;
            data_q   <= '0;
            wait_cnt <= '0;
        end else begin
            state_q <= state_d;
            adr_q   <= adress;
            data_q  <= data;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        src_q <= src_addr;
                        dst_q <= dst_addr;
                        rem_q <= length;
                        wc_q  <= '0;
                    end
                end
                READ: wait_cnt <= '0;
                WAIT: begin
                    if (last_wait) buf_q <= memOut;
                    else           wait_cnt <= wait_cnt + 1'b1;
                end
                WRITE: begin
                    src_q <= src_q + 32'd1;
                    dst_q <= dst_q + 32'd1;
                    wc_q  <= wc_q + 8'd1;
                    rem_q <= rem_q - 8'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_copy_dma.sv
// tb/tb_mem_copy_dma.sv - directed self-checking bench for mem_copy_dma
module tb_mem_copy_dma;

    logic        clk = 1'b0;
    logic        reset, start;
    logic [31:0] src_addr, dst_addr;
    logic [7:0]  length;
    logic        busy, done, error, memRead, memWrite;
    logic [7:0]  words_copied;
    logic [31:0] adress, data, memOut;

    logic [31:0] mem [0:255];
    int          wr_cnt = 0;
    int          rd_cnt = 0;
    logic        bd_we;
    logic [7:0]  bd_addr;
    logic [31:0] bd_data;
    logic        both_seen = 1'b0;

    int total, bad;
    int bc, dc, ec, el, w0, r0;

    always #5 clk = ~clk;

    mem_copy_dma #(.MEM_DEPTH(200), .READ_LAT(1)) dut (
        .clk(clk), .reset(reset), .start(start),
        .src_addr(src_addr), .dst_addr(dst_addr), .length(length),
        .busy(busy), .done(done), .error(error), .words_copied(words_copied),
        .adress(adress), .data(data), .memRead(memRead), .memWrite(memWrite),
        .memOut(memOut)
    );

    // Memory with one-cycle read latency; backdoor port used only for preload
    always @(posedge clk) begin
        if (memRead) begin
            memOut <= mem[adress[7:0]];
            rd_cnt <= rd_cnt + 1;
        end
        if (memWrite) begin
            mem[adress[7:0]] <= data;
            wr_cnt <= wr_cnt + 1;
        end else if (bd_we) begin
            mem[bd_addr] <= bd_data;
        end
    end

    always @(negedge clk) if (memRead && memWrite) both_seen <= 1'b1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic poke(input int a, input logic [31:0] v);
        bd_we = 1'b1;
        bd_addr = 8'(a);
        bd_data = v;
        step();
        bd_we = 1'b0;
    endtask

    // Issues one start and watches until a done/error pulse plus two idle cycles
    task automatic run_copy(input logic [31:0] s, input logic [31:0] d, input logic [7:0] l,
                            input bit glitch, output int bcyc, output int dcnt,
                            output int ecnt, output int endlat);
        bcyc = 0; dcnt = 0; ecnt = 0; endlat = 0;
        start = 1'b1; src_addr = s; dst_addr = d; length = l;
        step();
        start = 1'b0;
        for (int k = 0; k < 300; k++) begin
            if (glitch && k == 2) begin
                start = 1'b1; src_addr = 32'd40; dst_addr = 32'd70; length = 8'd5;
            end
            if (glitch && k == 3) start = 1'b0;
            if (busy) bcyc++;
            if (done) dcnt++;
            if (error) ecnt++;
            if ((done || error) && endlat == 0) endlat = k + 1;
            if (endlat != 0 && k >= endlat + 2) break;
            step();
        end
        total++;
        assert (endlat != 0) else begin
            bad++;
            $error("FAIL timeout observed=no_end expected=done_or_error");
        end
    endtask

    initial begin
        total = 0; bad = 0;
        reset = 1'b0; start = 1'b0;
        src_addr = '0; dst_addr = '0; length = '0;
        bd_we = 1'b0; bd_addr = '0; bd_data = '0;

        #3;
        check("reset_ctrl", {19'b0, busy, done, error, memRead, memWrite, words_copied}, 32'd0);
        check("reset_adress", adress, 32'd0);
        check("reset_data", data, 32'd0);

        for (int i = 0; i < 200; i++)
            poke(i, (i == 105) ? 32'd5 : (i == 106) ? 32'd4 : 32'h1000 + 32'(i));
        reset = 1'b1;
        step();

        w0 = wr_cnt;
        run_copy(32'd105, 32'd150, 8'd2, 1'b0, bc, dc, ec, el);
        check("c1_busy_cycles", 32'(bc), 32'd7);
        check("c1_done_pulses", 32'(dc), 32'd1);
        check("c1_error_pulses", 32'(ec), 32'd0);
        check("c1_done_latency", 32'(el), 32'd8);
        check("c1_words", {24'b0, words_copied}, 32'd2);
        check("c1_mem150", mem[150], 32'd5);
        check("c1_mem151", mem[151], 32'd4);
        check("c1_writes", 32'(wr_cnt - w0), 32'd2);

        w0 = wr_cnt;
        run_copy(32'd190, 32'd10, 8'd20, 1'b0, bc, dc, ec, el);
        check("oob_error_pulses", 32'(ec), 32'd1);
        check("oob_error_latency", 32'(el), 32'd2);
        check("oob_done_pulses", 32'(dc), 32'd0);
        check("oob_writes", 32'(wr_cnt - w0), 32'd0);
        check("oob_words", {24'b0, words_copied}, 32'd0);

        run_copy(32'd100, 32'd102, 8'd4, 1'b0, bc, dc, ec, el);
        check("fwd_ovl_error", 32'(ec), 32'd1);
        check("fwd_ovl_done", 32'(dc), 32'd0);

        run_copy(32'd102, 32'd100, 8'd4, 1'b0, bc, dc, ec, el);
        check("bwd_ovl_done", 32'(dc), 32'd1);
        check("bwd_ovl_busy", 32'(bc), 32'd13);
        check("bwd_mem100", mem[100], 32'h1066);
        check("bwd_mem101", mem[101], 32'h1067);
        check("bwd_mem102", mem[102], 32'h1068);
        check("bwd_mem103", mem[103], 32'd5);

        w0 = wr_cnt; r0 = rd_cnt;
        run_copy(32'd3, 32'd4, 8'd0, 1'b0, bc, dc, ec, el);
        check("len0_done", 32'(dc), 32'd1);
        check("len0_latency", 32'(el), 32'd2);
        check("len0_reads", 32'(rd_cnt - r0), 32'd0);
        check("len0_writes", 32'(wr_cnt - w0), 32'd0);

        w0 = wr_cnt;
        run_copy(32'd20, 32'd20, 8'd2, 1'b0, bc, dc, ec, el);
        check("same_done", 32'(dc), 32'd1);
        check("same_writes", 32'(wr_cnt - w0), 32'd2);
        check("same_mem20", mem[20], 32'h1014);
        check("same_mem21", mem[21], 32'h1015);

        run_copy(32'd198, 32'd0, 8'd2, 1'b0, bc, dc, ec, el);
        check("edge_fit_done", 32'(dc), 32'd1);
        check("edge_fit_mem0", mem[0], 32'h10C6);
        check("edge_fit_mem1", mem[1], 32'h10C7);
        run_copy(32'd199, 32'd0, 8'd2, 1'b0, bc, dc, ec, el);
        check("edge_over_error", 32'(ec), 32'd1);

        w0 = wr_cnt;
        run_copy(32'd30, 32'd60, 8'd3, 1'b1, bc, dc, ec, el);
        check("glitch_done", 32'(dc), 32'd1);
        check("glitch_words", {24'b0, words_copied}, 32'd3);
        check("glitch_writes", 32'(wr_cnt - w0), 32'd3);
        check("glitch_mem60", mem[60], 32'h101E);
        check("glitch_mem62", mem[62], 32'h1020);
        check("glitch_mem63", mem[63], 32'h103F);
        check("glitch_mem70", mem[70], 32'h1046);

        w0 = wr_cnt;
        start = 1'b1; src_addr = 32'd50; dst_addr = 32'd80; length = 8'd10;
        step();
        start = 1'b0;
        repeat (6) step();
        check("rst_in_write", {31'b0, memWrite}, 32'd1);
        #2 reset = 1'b0;
        #1;
        check("rst_strobes", {29'b0, memRead, memWrite, busy}, 32'd0);
        check("rst_words", {24'b0, words_copied}, 32'd0);
        check("rst_adress", adress, 32'd0);
        check("rst_data", data, 32'd0);
        step();
        step();
        reset = 1'b1;
        step();
        check("rst_mem80", mem[80], 32'h1032);
        check("rst_mem81", mem[81], 32'h1051);
        check("rst_writes", 32'(wr_cnt - w0), 32'd1);

        run_copy(32'd50, 32'd90, 8'd1, 1'b0, bc, dc, ec, el);
        check("post_rst_done", 32'(dc), 32'd1);
        check("post_rst_mem90", mem[90], 32'h1032);
        check("post_rst_words", {24'b0, words_copied}, 32'd1);

        check("strobe_exclusive", {31'b0, both_seen}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_copy_dma.md
MEM_COPY_DMA -- requirements
Module: mem_copy_dma

Interface
REQ-001 Parameter MEM_DEPTH, default 200, number of 32-bit words in the attached memory.
REQ-002 Parameter READ_LAT, default 1, number of clk cycles from memRead sampled to memOut valid.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle request to begin a copy; sampled only in IDLE.
REQ-006 src_addr  input  32  first source word address.
REQ-007 dst_addr  input  32  first destination word address.
REQ-008 length  input  8  number of words to copy.
REQ-009 busy  output  1  high from the cycle after start is accepted until the cycle DONE or ERROR is entered.
REQ-010 done  output  1  one-cycle pulse when a copy completes.
REQ-011 error  output  1  one-cycle pulse when a request is rejected.
REQ-012 words_copied  output  8  count of words written in the current or last copy.
REQ-013 adress  output  32  memory word address.
REQ-014 data  output  32  memory write data.
REQ-015 memRead  output  1  memory read strobe.
REQ-016 memWrite  output  1  memory write strobe.
REQ-017 memOut  input  32  memory read data.

Function
REQ-018 The FSM SHALL have states IDLE, CHECK, READ, WAIT, WRITE, DONE and ERROR.
REQ-019 IDLE->CHECK on start=1: latch src_addr, dst_addr and length; clear words_copied.
REQ-020 start while not in IDLE SHALL be ignored, with no effect on the latched parameters.
REQ-021 CHECK->ERROR when any of the following holds; otherwise CHECK->DONE if length=0, else CHECK->READ:
  - src+len > MEM_DEPTH;
  - dst+len > MEM_DEPTH;
  - src < dst < src+len (forward-overlap corruption).
  Sums SHALL be computed at 33 bits so no wrap-around occurs.
REQ-022 READ lasts 1 cycle: memRead=1, memWrite=0, adress=current src.
REQ-023 WAIT lasts READ_LAT cycles:
  - memRead held 1 and adress held at current src;
  - memOut captured into a 32-bit buffer on the last WAIT edge.
REQ-024 WRITE lasts 1 cycle: memWrite=1, memRead=0, adress=current dst, data=buffer.
REQ-025 On exit from WRITE:
  - src, dst and words_copied increment by 1;
  - remaining count decrements by 1;
  - next state is DONE if remaining reaches 0, else READ.
REQ-026 With READ_LAT=1 each word SHALL take exactly 3 cycles (READ, WAIT, WRITE).
REQ-027 memRead and memWrite SHALL never be 1 in the same cycle.
REQ-028 In IDLE, CHECK, DONE and ERROR both strobes SHALL be 0, and adress and data SHALL hold their last values.
REQ-029 DONE and ERROR each last one cycle, assert done or error respectively, then return to IDLE.
REQ-030 dst=src with non-zero length is legal; the copy SHALL rewrite the same words.
REQ-031 dst < src overlap is legal; forward copy order SHALL give the correct result.

Reset
REQ-032 reset=0 SHALL immediately force IDLE regardless of clk, aborting any copy mid-word with no further write.
REQ-033 reset=0 SHALL also drive the following to 0: busy, done, error, memRead, memWrite, words_copied, adress, data, buffer and internal counters.
REQ-034 Operation SHALL resume on the first rising clk edge after reset returns to 1.

Verification
REQ-035 Preload mem[105]=5, mem[106]=4; start with src=105, dst=150, len=2 ->
  - busy for 7 cycles;
  - mem[150]=5, mem[151]=4;
  - done pulses once;
  - words_copied=2.
REQ-036 Start with src=190, dst=10, len=20 -> error pulses 2 cycles after start; no memWrite ever asserted; words_copied=0.
REQ-037 Start with src=100, dst=102, len=4 -> error. Start with src=102, dst=100, len=4 -> done, with mem[100..103] = original mem[102..105].
REQ-038 Start with len=0 -> done pulses 2 cycles after start; no memRead or memWrite asserted.
REQ-039 Start a len=10 copy and assert reset=0 on the second WRITE cycle ->
  - strobes drop asynchronously;
  - only dst word 0 is modified.
  After release, a new start performs a normal copy.
REQ-040 Pulse start again while busy -> ignored; the original copy completes with its original parameters; a monitor checks memRead & memWrite never both 1 across all scenarios.
